// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Chunk counter width; never narrower than one bit, even for a single chunk.
    function automatic int cnt_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/serial_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    // Carry into the top bit; combined with cout it gives signed overflow.
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a registered carry.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output state_e           dbg_state
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
    logic [CHUNK-1:0] a_ch, b_ch, ch_s;
    logic             ch_cout, ch_cmsb;
    logic             last;

    assign a_ch = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign b_ch = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign last = (cnt_q == CW'(NCH - 1));

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_ch),
        .b     (b_ch),
        .cin   (carry_q),
        .s     (ch_s),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    always_comb begin
        acc_next = acc_q;
        acc_next[int'(cnt_q)*CHUNK +: CHUNK] = ch_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    // Subtraction is a + ~b + 1; the caller's cin is dropped.
                    a_q     <= a;
                    b_q     <= sub ? ~b : b;
                    carry_q <= sub ? 1'b1 : cin;
                    cnt_q   <= '0;
                end
                RUN: begin
                    acc_q   <= acc_next;
                    carry_q <= ch_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        sum  <= acc_next;
                        cout <= ch_cout;
                        ovf  <= ch_cmsb ^ ch_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: CHUNK=4 and CHUNK=WIDTH builds.
module tb_serial_addsub;
    import addsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // CHUNK=4 instance
    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;
    state_e      dbg_state;

    // CHUNK=16 instance
    logic        w_in_valid = 1'b0, w_out_ready = 1'b0, w_cin = 1'b0, w_sub = 1'b0;
    logic [15:0] w_a = '0, w_b = '0;
    logic        w_in_ready, w_out_valid, w_cout, w_ovf;
    logic [15:0] w_sum;
    state_e      w_dbg_state;

    serial_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
        .dbg_state(dbg_state)
    );

    serial_addsub #(.WIDTH(16), .CHUNK(16)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .ovf(w_ovf),
        .dbg_state(w_dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold in_valid until the accept edge has passed.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                            input logic ci, input logic sb);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb, input logic [15:0] es,
                          input logic ec, input logic eo);
        int lat;
        start_op(av, bv, ci, sb);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_done(lat);
        check({tag, "_lat"}, lat, 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int lat;
        int seen;

        #12;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_iready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        run_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("uwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("swrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Backpressure, with stray in_valid pulses during RUN and DONE
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        check("bp_state_run", 32'(dbg_state), 32'(RUN));
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; in_valid = 1'b1;
        wait_done(lat);
        check("bp_lat", lat, 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("bp_ovalid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h3333);
            check("bp_iready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release", 32'(out_valid), 32'd0);
        check("bp_final_sum", 32'(sum), 32'h3333);
        check("bp_idle_state", 32'(dbg_state), 32'(IDLE));
        tick();
        check("bp_no_stray", 32'(dbg_state), 32'(IDLE));

        // Reset after two RUN cycles abandons the operation
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_ovalid", 32'(out_valid), 32'd0);
        check("mid_rst_iready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("mid_rst_no_result", seen, 32'd0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Single-chunk build
        w_a = 16'hAAAA; w_b = 16'h5555; w_cin = 1'b1; w_sub = 1'b0;
        check("w_ready", 32'(w_in_ready), 32'd1);
        w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("w_lat", lat, 32'd1);
        check("w_sum", 32'(w_sum), 32'h0000);
        check("w_cout", 32'(w_cout), 32'd1);
        check("w_ovf", 32'(w_ovf), 32'd0);
        w_out_ready = 1'b1;
        tick();
        w_out_ready = 1'b0;
        check("w_drop", 32'(w_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
